subneg_sequencer: RTL and testbench
===================================

SUBNEG_SEQUENCER -- requirements
Module: subneg_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data/address width of the SUBNEG datapath.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, run request; sampled in IDLE and HALT.
REQ-005 SHALL have port stop, input, 1, halt request; honored at the next instruction boundary.
REQ-006 SHALL have port neg, input, 1, subtractor sign flag; valid in EXEC.
REQ-007 SHALL have port pc, input, WIDTH, current program-counter value.
REQ-008 SHALL have port target, input, WIDTH, branch-target word C from data path; valid in BRANCH.
REQ-009 SHALL have ports write_op1, write_op2, write_mem, write_pc, all output, 1, register/memory write enables.
REQ-010 SHALL have port sel_pc, output, 1, PC mux select: 0 = pc+1, 1 = target.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE and HALT.
REQ-012 SHALL have port halted, output, 1, high only in HALT.
REQ-013 SHALL have port instr_count, output, 16, completed-instruction counter.
REQ-014 SHALL have port state, output, 3, FSM state encoding for debug.

Function
REQ-015 SHALL implement states IDLE=0, FETCH_A=1, LOAD_A=2, FETCH_B=3, LOAD_B=4, EXEC=5, FETCH_C=6, BRANCH=7; HALT is a further state encoded in addition to these (state width grows to hold it: HALT reported as 0 with halted=1).
REQ-016 SHALL move IDLE->FETCH_A when start=1; otherwise remain IDLE with all enables 0.
REQ-017 SHALL sequence FETCH_A->LOAD_A->FETCH_B->LOAD_B->EXEC->FETCH_C->BRANCH unconditionally, one cycle each; one instruction = 7 cycles.
REQ-018 SHALL capture pc into internal instr_addr in FETCH_A.
REQ-019 SHALL assert write_op1 and write_pc with sel_pc=0 in LOAD_A only.
REQ-020 SHALL assert write_op2 and write_pc with sel_pc=0 in LOAD_B only.
REQ-021 SHALL assert write_mem in EXEC only and register neg into neg_q at the end of EXEC.
REQ-022 SHALL assert no enables in FETCH_A, FETCH_B, FETCH_C (memory read latency 1 cycle).
REQ-023 SHALL in BRANCH assert write_pc with sel_pc=neg_q.
REQ-024 SHALL increment instr_count at the end of every BRANCH, saturating at 0xFFFF.
REQ-025 SHALL leave BRANCH to HALT when neg_q=1 and target==instr_addr (self-loop halt), else to HALT when stop_q=1, else to FETCH_A.
REQ-026 SHALL set stop_q when stop=1 in any non-HALT state; clear stop_q on entering HALT.
REQ-027 SHALL in HALT hold all enables 0; start=1 moves HALT->FETCH_A (resume from current pc).
REQ-028 SHALL, when start and stop are both 1 in IDLE, go to FETCH_A with stop_q set: exactly one instruction executes, then HALT.
REQ-029 SHALL never assert more than one of write_op1, write_op2, write_mem in the same cycle.
REQ-030 SHALL drive all outputs from registered state only (Moore); no input-to-output combinational path.

Reset
REQ-031 SHALL on rst=1 at a clock edge enter IDLE, clear neg_q, stop_q, instr_addr, instr_count; rst overrides start/stop and any state, including mid-instruction.
REQ-032 SHALL drive after reset: all enables 0, sel_pc=0, busy=0, halted=0, instr_count=0, state=0.

Verification
REQ-033 Reset then start pulse -> enables appear in order write_op1+write_pc (cycle 2), write_op2+write_pc (cycle 4), write_mem (cycle 5), write_pc (cycle 7); instr_count=1 after cycle 7.
REQ-034 neg=1 in EXEC, target=0x20 != instr_addr -> BRANCH sel_pc=1, write_pc=1, next state FETCH_A; neg=0 -> sel_pc=0.
REQ-035 pc=0x10 at FETCH_A, neg=1, target=0x10 -> HALT after BRANCH, halted=1, busy=0, instr_count incremented; start then resumes at FETCH_A.
REQ-036 stop pulse during EXEC -> current instruction completes, HALT entered after BRANCH; stop_q cleared.
REQ-037 rst asserted in LOAD_B -> next cycle IDLE, all enables 0, instr_count=0; start then re-runs from FETCH_A.
REQ-038 Preload instr_count path with 0xFFFF completions (or force) -> further instructions leave instr_count=0xFFFF.

Source files
------------

// File: rtl/subneg_sequencer.sv
// Control sequencer for a one-instruction SUBNEG CPU: 7 cycles per instruction,
// Moore outputs, with self-loop and stop-request halting.
module subneg_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             neg,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] target,
  output logic             write_op1,
  output logic             write_op2,
  output logic             write_mem,
  output logic             write_pc,
  output logic             sel_pc,
  output logic             busy,
  output logic             halted,
  output logic [15:0]      instr_count,
  output logic [2:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH_A = 4'd1,
    S_LOAD_A  = 4'd2,
    S_FETCH_B = 4'd3,
    S_LOAD_B  = 4'd4,
    S_EXEC    = 4'd5,
    S_FETCH_C = 4'd6,
    S_BRANCH  = 4'd7,
    S_HALT    = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic             neg_q, neg_d;
  logic             stop_q, stop_d;
  logic [WIDTH-1:0] instr_addr_q, instr_addr_d;
  logic [15:0]      instr_count_q, instr_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      neg_q         <= 1'b0;
      stop_q        <= 1'b0;
      instr_addr_q  <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      neg_q         <= neg_d;
      stop_q        <= stop_d;
      instr_addr_q  <= instr_addr_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    neg_d         = neg_q;
    stop_d        = stop_q;
    instr_addr_d  = instr_addr_q;
    instr_count_d = instr_count_q;
    if (state_q != S_HALT && stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH_A;
      S_FETCH_A: begin
        instr_addr_d = pc;
        state_d      = S_LOAD_A;
      end
      S_LOAD_A:  state_d = S_FETCH_B;
      S_FETCH_B: state_d = S_LOAD_B;
      S_LOAD_B:  state_d = S_EXEC;
      S_EXEC: begin
        neg_d   = neg;
        state_d = S_FETCH_C;
      end
      S_FETCH_C: state_d = S_BRANCH;
      S_BRANCH: begin
        if (instr_count_q != 16'hFFFF) instr_count_d = instr_count_q + 16'd1;
        // A taken branch back onto its own instruction can never make progress.
        if ((neg_q && target == instr_addr_q) || stop_q) begin
          state_d = S_HALT;
          stop_d  = 1'b0;
        end else begin
          state_d = S_FETCH_A;
        end
      end
      S_HALT:    if (start) state_d = S_FETCH_A;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    write_op1 = 1'b0;
    write_op2 = 1'b0;
    write_mem = 1'b0;
    write_pc  = 1'b0;
    sel_pc    = 1'b0;
    case (state_q)
      S_LOAD_A: begin
        write_op1 = 1'b1;
        write_pc  = 1'b1;
      end
      S_LOAD_B: begin
        write_op2 = 1'b1;
        write_pc  = 1'b1;
      end
      S_EXEC:   write_mem = 1'b1;
      S_BRANCH: begin
        write_pc = 1'b1;
        sel_pc   = neg_q;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);
  assign instr_count = instr_count_q;
  assign state       = (state_q == S_HALT) ? 3'd0 : state_q[2:0];

endmodule

// File: tb/tb_subneg_sequencer.sv
// Directed bench for subneg_sequencer; output vector = {state, halted, busy, sel_pc,
// write_pc, write_mem, write_op2, write_op1}.
module tb_subneg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        neg = 1'b0;
  logic [7:0]  pc = 8'h00;
  logic [7:0]  target = 8'h00;
  logic        write_op1, write_op2, write_mem, write_pc, sel_pc, busy, halted;
  logic [15:0] instr_count;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [9:0] E_IDLE = 10'b000_0_0_0_0_0_0_0;
  localparam logic [9:0] E_FA   = 10'b001_0_1_0_0_0_0_0;
  localparam logic [9:0] E_LA   = 10'b010_0_1_0_1_0_0_1;
  localparam logic [9:0] E_FB   = 10'b011_0_1_0_0_0_0_0;
  localparam logic [9:0] E_LB   = 10'b100_0_1_0_1_0_1_0;
  localparam logic [9:0] E_EX   = 10'b101_0_1_0_0_1_0_0;
  localparam logic [9:0] E_FC   = 10'b110_0_1_0_0_0_0_0;
  localparam logic [9:0] E_BR0  = 10'b111_0_1_0_1_0_0_0;
  localparam logic [9:0] E_BR1  = 10'b111_0_1_1_1_0_0_0;
  localparam logic [9:0] E_HALT = 10'b000_1_0_0_0_0_0_0;

  subneg_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .neg(neg), .pc(pc), .target(target),
    .write_op1(write_op1), .write_op2(write_op2), .write_mem(write_mem), .write_pc(write_pc),
    .sel_pc(sel_pc), .busy(busy), .halted(halted), .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {state, halted, busy, sel_pc, write_pc, write_mem, write_op2, write_op1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction starting from FETCH_A; pc only valid during FETCH_A.
  task automatic run_instr(input logic [7:0] pc_v, input logic neg_v,
                           input logic [7:0] tgt_v, input logic stop_exec);
    target = tgt_v;
    for (int i = 0; i < 7; i++) begin
      pc   = (i == 0) ? pc_v : pc_v + 8'd3;
      neg  = (i == 4) ? neg_v : 1'b0;
      stop = (i == 4) ? stop_exec : 1'b0;
      tick();
    end
    neg  = 1'b0;
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    tick(); tick();
    vectors++;
    if (outs() !== E_IDLE || instr_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_outs: got %b cnt %h want %b cnt 0000", outs(), instr_count, E_IDLE);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    vectors++;
    if (outs() !== E_IDLE) begin
      miscompares++;
      $display("FAIL idle_hold: got %b want %b", outs(), E_IDLE);
    end
  endtask

  task automatic test_basic();
    logic [9:0] exp_seq [7] = '{E_FA, E_LA, E_FB, E_LB, E_EX, E_FC, E_BR0};
    start = 1'b1;
    tick();
    start = 1'b0;
    target = 8'h20;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (outs() !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL basic_cycle%0d: got %b want %b", i + 1, outs(), exp_seq[i]);
      end
      pc  = (i == 0) ? 8'h05 : 8'h08;
      neg = 1'b0;
      tick();
    end
    vectors++;
    if (outs() !== E_FA || instr_count !== 16'd1) begin
      miscompares++;
      $display("FAIL basic_end: got %b cnt %0d want %b cnt 1", outs(), instr_count, E_FA);
    end
  endtask

  task automatic test_branch_taken();
    logic [9:0] exp_seq [7] = '{E_FA, E_LA, E_FB, E_LB, E_EX, E_FC, E_BR1};
    target = 8'h20;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (outs() !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL taken_cycle%0d: got %b want %b", i + 1, outs(), exp_seq[i]);
      end
      pc  = (i == 0) ? 8'h06 : 8'h09;
      neg = (i == 4);
      tick();
    end
    neg = 1'b0;
    vectors++;
    if (outs() !== E_FA || instr_count !== 16'd2) begin
      miscompares++;
      $display("FAIL taken_end: got %b cnt %0d want %b cnt 2", outs(), instr_count, E_FA);
    end
    // Target matches the instruction address but branch not taken: no halt.
    run_instr(8'h30, 1'b0, 8'h30, 1'b0);
    vectors++;
    if (outs() !== E_FA || instr_count !== 16'd3) begin
      miscompares++;
      $display("FAIL notaken_self: got %b cnt %0d want %b cnt 3", outs(), instr_count, E_FA);
    end
  endtask

  task automatic test_self_loop_halt();
    run_instr(8'h10, 1'b1, 8'h10, 1'b0);
    vectors++;
    if (outs() !== E_HALT || instr_count !== 16'd4) begin
      miscompares++;
      $display("FAIL selfloop_halt: got %b cnt %0d want %b cnt 4", outs(), instr_count, E_HALT);
    end
    tick(); tick();
    vectors++;
    if (outs() !== E_HALT) begin
      miscompares++;
      $display("FAIL halt_hold: got %b want %b", outs(), E_HALT);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (outs() !== E_FA) begin
      miscompares++;
      $display("FAIL halt_resume: got %b want %b", outs(), E_FA);
    end
  endtask

  task automatic test_stop();
    run_instr(8'h11, 1'b0, 8'h40, 1'b1);
    vectors++;
    if (outs() !== E_HALT || instr_count !== 16'd5) begin
      miscompares++;
      $display("FAIL stop_halt: got %b cnt %0d want %b cnt 5", outs(), instr_count, E_HALT);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    run_instr(8'h12, 1'b0, 8'h40, 1'b0);
    vectors++;
    if (outs() !== E_FA || instr_count !== 16'd6) begin
      miscompares++;
      $display("FAIL stop_cleared: got %b cnt %0d want %b cnt 6", outs(), instr_count, E_FA);
    end
  endtask

  task automatic test_start_stop_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    vectors++;
    if (outs() !== E_FA) begin
      miscompares++;
      $display("FAIL startstop_go: got %b want %b", outs(), E_FA);
    end
    run_instr(8'h50, 1'b0, 8'h60, 1'b0);
    vectors++;
    if (outs() !== E_HALT || instr_count !== 16'd1) begin
      miscompares++;
      $display("FAIL startstop_one: got %b cnt %0d want %b cnt 1", outs(), instr_count, E_HALT);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (outs() !== E_LB) begin
      miscompares++;
      $display("FAIL mid_reach_loadb: got %b want %b", outs(), E_LB);
    end
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    vectors++;
    if (outs() !== E_IDLE || instr_count !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got %b cnt %0d want %b cnt 0", outs(), instr_count, E_IDLE);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (outs() !== E_FA) begin
      miscompares++;
      $display("FAIL mid_rerun: got %b want %b", outs(), E_FA);
    end
  endtask

  task automatic test_saturate();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    force dut.instr_count_q = 16'hFFFE;
    tick();
    release dut.instr_count_q;
    tick();
    vectors++;
    if (instr_count !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL sat_preload: got %h want fffe", instr_count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    run_instr(8'h01, 1'b0, 8'h02, 1'b0);
    vectors++;
    if (instr_count !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_reach: got %h want ffff", instr_count);
    end
    run_instr(8'h02, 1'b1, 8'h07, 1'b0);
    vectors++;
    if (instr_count !== 16'hFFFF || outs() !== E_FA) begin
      miscompares++;
      $display("FAIL sat_hold: got %h %b want ffff %b", instr_count, outs(), E_FA);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch_taken();
    test_self_loop_halt();
    test_stop();
    test_start_stop_idle();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
